// File: rtl/ffmodes_pkg.sv
// rtl/ffmodes_pkg.sv - shared FSM encoding and counter sizing for the ffmodes receiver
package ffmodes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_PAR   = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  // Counter must hold 0..WIDTH
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ffmodes_linesync.sv
// rtl/ffmodes_linesync.sv - negedge capture then posedge retime of the serial line, both async-set
module ffmodes_linesync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sin_n;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) sin_n <= 1'b1;
    else     sin_n <= d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b1;
    else     q <= sin_n;
  end

endmodule

// File: rtl/ffmodes_rx.sv
// rtl/ffmodes_rx.sv - start/data/parity/stop deframer exercising every flop mode
module ffmodes_rx
  import ffmodes_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             clr,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             perr,
  output logic             ferr,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  logic             sin_p;
  state_e           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg, shreg_shift;
  logic             parbit;
  logic             accept, frame_err, par_bad;

  ffmodes_linesync u_linesync (
    .clk (clk),
    .rst (rst),
    .d   (sin),
    .q   (sin_p)
  );

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    frame_err   = 1'b0;
    shreg_shift = shreg >> 1;
    shreg_shift[WIDTH-1] = sin_p;
    par_bad     = ((^shreg) ^ parbit) != PARITY_ODD;
    if (cen) begin
      case (state)
        ST_IDLE:  if (!sin_p) state_nxt = ST_DATA;
        ST_DATA:  if (cnt == CW'(WIDTH - 1)) state_nxt = ST_PAR;
        ST_PAR:   state_nxt = ST_STOP;
        ST_STOP: begin
          if (sin_p) begin
            accept    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
        ST_BREAK: if (sin_p) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // busy tracks the next state so it equals (state != IDLE) with no extra lag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      dvalid <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt != ST_IDLE);
      dvalid <= accept;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      shreg  <= '0;
      parbit <= 1'b0;
      dout   <= '0;
    end else if (cen) begin
      case (state)
        ST_IDLE: cnt <= '0;
        ST_DATA: begin
          shreg <= shreg_shift;
          cnt   <= cnt + CW'(1);
        end
        ST_PAR:  parbit <= sin_p;
        default: ;
      endcase
      if (accept) dout <= shreg;
    end
  end

  // A new error event outranks clr so that no error is ever dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (accept && par_bad) perr <= 1'b1;
      else if (clr)          perr <= 1'b0;
      if (frame_err)         ferr <= 1'b1;
      else if (clr)          ferr <= 1'b0;
    end
  end

endmodule
